// File: rtl/addsub_pkg.sv
// Shared lane constants and stage-1 control payload for the addsub_pipe
// pipelined saturating adder/subtractor.
package addsub_pkg;

    localparam int LANE_W = 4;

    localparam logic [LANE_W-1:0] LANE_POS_MAX = 4'b0111;
    localparam logic [LANE_W-1:0] LANE_NEG_MIN = 4'b1000;

    // Width-independent part of the stage-1 payload; the WIDTH-dependent
    // operand/result fields wrap this inside the top module.
    typedef struct packed {
        logic carry;
        logic sub;
        logic sat;
        logic packed_mode;
    } s1_ctrl_t;

endpackage

// File: rtl/addsub_pipe_cla_lane4.sv
// 4-bit carry-lookahead lane with carry-in, carry-out and signed overflow.
module cla_lane4
    import addsub_pkg::*;
(
    input  logic [LANE_W-1:0] i_a,
    input  logic [LANE_W-1:0] i_b,
    input  logic              i_cin,
    output logic [LANE_W-1:0] o_sum,
    output logic              o_cout,
    output logic              o_ovf
);

    logic [LANE_W-1:0] w_g;
    logic [LANE_W-1:0] w_p;
    logic [LANE_W:0]   w_c;

    assign w_g    = i_a & i_b;
    assign w_p    = i_a ^ i_b;
    assign w_c[0] = i_cin;
    assign w_c[1] = w_g[0] | (w_p[0] & w_c[0]);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_c[0]);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & w_c[0]);
    assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_c[0]);

    assign o_sum  = w_p ^ w_c[LANE_W-1:0];
    assign o_cout = w_c[LANE_W];
    // b arrives already inverted for subtraction, so this is the plain add rule
    assign o_ovf  = (i_a[LANE_W-1] == i_b[LANE_W-1]) && (o_sum[LANE_W-1] != i_a[LANE_W-1]);

endmodule

// File: rtl/addsub_pipe.sv
// Two-stage saturating add/sub, full-width or packed 4-bit lanes, with
// valid/ready handshake. Optional zero/neg flags: define ADDSUB_FLAGS_EN.
module addsub_pipe
    import addsub_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_sub,
    input  logic             i_sat,
    input  logic             i_packed,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout,
    output logic             o_ovf
`ifdef ADDSUB_FLAGS_EN
    ,
    output logic             o_zero,
    output logic             o_neg
`endif
);

    localparam int NL  = WIDTH / LANE_W;
    localparam int NLH = NL / 2;
    localparam int HW  = WIDTH / 2;

    typedef struct packed {
        logic [HW-1:0]  lo_sum;
        logic [NLH-1:0] lo_ovf;
        logic [HW-1:0]  a_hi;
        logic [HW-1:0]  b_hi;
        s1_ctrl_t       ctrl;
    } s1_payload_t;

    s1_payload_t      r_s1;
    s1_payload_t      w_s1_next;
    logic             r_s1_valid;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;

    logic [WIDTH-1:0] w_b_eff;
    logic [WIDTH-1:0] w_lane_a;
    logic [WIDTH-1:0] w_lane_b;
    logic [WIDTH-1:0] w_lane_sum;
    logic [NL-1:0]    w_lane_ovf;
    logic [WIDTH-1:0] w_raw;
    logic [NL-1:0]    w_ovf_all;
    logic             w_ovf;
    logic             w_cout;
    logic [WIDTH-1:0] w_sat_sum;
    logic             w_s2_adv;

    assign w_b_eff  = i_sub ? ~i_b : i_b;
    // Lower lanes see live operands (stage 1), upper lanes the registered half (stage 2)
    assign w_lane_a = {r_s1.a_hi, i_a[HW-1:0]};
    assign w_lane_b = {r_s1.b_hi, w_b_eff[HW-1:0]};

    for (genvar gi = 0; gi < NL; gi++) begin : g_lane
        logic w_cin;
        logic w_cout;
        if (gi == 0) begin : g_cin_first
            assign w_cin = i_sub;
        end else if (gi < NLH) begin : g_cin_lo
            assign w_cin = i_packed ? i_sub : g_lane[gi-1].w_cout;
        end else if (gi == NLH) begin : g_cin_mid
            assign w_cin = r_s1.ctrl.packed_mode ? r_s1.ctrl.sub : r_s1.ctrl.carry;
        end else begin : g_cin_hi
            assign w_cin = r_s1.ctrl.packed_mode ? r_s1.ctrl.sub : g_lane[gi-1].w_cout;
        end
        cla_lane4 u_lane (
            .i_a   (w_lane_a[gi*LANE_W +: LANE_W]),
            .i_b   (w_lane_b[gi*LANE_W +: LANE_W]),
            .i_cin (w_cin),
            .o_sum (w_lane_sum[gi*LANE_W +: LANE_W]),
            .o_cout(w_cout),
            .o_ovf (w_lane_ovf[gi])
        );
    end

    assign w_s1_next.lo_sum           = w_lane_sum[HW-1:0];
    assign w_s1_next.lo_ovf           = w_lane_ovf[NLH-1:0];
    assign w_s1_next.a_hi             = i_a[WIDTH-1:HW];
    assign w_s1_next.b_hi             = w_b_eff[WIDTH-1:HW];
    assign w_s1_next.ctrl.carry       = g_lane[NLH-1].w_cout;
    assign w_s1_next.ctrl.sub         = i_sub;
    assign w_s1_next.ctrl.sat         = i_sat;
    assign w_s1_next.ctrl.packed_mode = i_packed;

    assign w_raw     = {w_lane_sum[WIDTH-1:HW], r_s1.lo_sum};
    assign w_ovf_all = {w_lane_ovf[NL-1:NLH], r_s1.lo_ovf};
    assign w_ovf     = r_s1.ctrl.packed_mode ? (|w_ovf_all) : w_ovf_all[NL-1];
    assign w_cout    = g_lane[NL-1].w_cout;

    assign w_s2_adv    = !r_out_valid || i_out_ready;
    assign o_in_ready  = !i_rst && (!r_s1_valid || w_s2_adv);
    assign o_out_valid = r_out_valid;
    assign o_sum       = r_sum;
    assign o_cout      = r_cout;
    assign o_ovf       = r_ovf;

    // Saturation: an overflowed result with sign 1 came from positive operands
    always_comb begin
        w_sat_sum = w_raw;
        if (r_s1.ctrl.sat && r_s1.ctrl.packed_mode) begin
            for (int i = 0; i < NL; i++) begin
                if (w_ovf_all[i]) begin
                    w_sat_sum[i*LANE_W +: LANE_W] = w_raw[i*LANE_W + LANE_W - 1] ? LANE_POS_MAX : LANE_NEG_MIN;
                end else begin
                    w_sat_sum[i*LANE_W +: LANE_W] = w_raw[i*LANE_W +: LANE_W];
                end
            end
        end else if (r_s1.ctrl.sat && w_ovf) begin
            w_sat_sum = w_raw[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};
        end else begin
            w_sat_sum = w_raw;
        end
    end

    // Valid bits: stage 1 refills when it can hand off, stage 2 when drained
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1_valid  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            if (o_in_ready) begin
                r_s1_valid <= i_in_valid;
            end
            if (w_s2_adv) begin
                r_out_valid <= r_s1_valid;
            end
        end
    end

    // Stage-1 payload capture on acceptance
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1 <= '0;
        end else if (i_in_valid && o_in_ready) begin
            r_s1 <= w_s1_next;
        end
    end

    // Result register, held while the consumer stalls
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sum  <= {WIDTH{1'b0}};
            r_cout <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (r_s1_valid && w_s2_adv) begin
            r_sum  <= w_sat_sum;
            r_cout <= w_cout;
            r_ovf  <= w_ovf;
        end
    end

`ifdef ADDSUB_FLAGS_EN
    logic r_zero;
    logic r_neg;

    assign o_zero = r_zero;
    assign o_neg  = r_neg;

    // Flags track the post-saturation result
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_zero <= 1'b0;
            r_neg  <= 1'b0;
        end else if (r_s1_valid && w_s2_adv) begin
            r_zero <= (w_sat_sum == {WIDTH{1'b0}});
            r_neg  <= w_sat_sum[WIDTH-1];
        end
    end
`endif

endmodule

// File: tb/tb_addsub_pipe.sv
// Directed self-checking bench for addsub_pipe (WIDTH=16); covers the
// ADDSUB_FLAGS_EN outputs when that macro is defined.
module tb_addsub_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic        sat;
    logic        pk;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
`ifdef ADDSUB_FLAGS_EN
    logic        zero;
    logic        neg;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    addsub_pipe #(.WIDTH(16)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_in_valid (in_valid),
        .o_in_ready (in_ready),
        .i_a        (a),
        .i_b        (b),
        .i_sub      (sub),
        .i_sat      (sat),
        .i_packed   (pk),
        .o_out_valid(out_valid),
        .i_out_ready(out_ready),
        .o_sum      (sum),
        .o_cout     (cout),
        .o_ovf      (ovf)
`ifdef ADDSUB_FLAGS_EN
        ,
        .o_zero     (zero),
        .o_neg      (neg)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [15:0] va, input logic [15:0] vb,
                         input logic vsub, input logic vsat, input logic vpk);
        a = va; b = vb; sub = vsub; sat = vsat; pk = vpk; in_valid = 1'b1;
    endtask

    // Issue one operation at a negedge and check its result two cycles later.
    // Controls are scrambled after acceptance to prove they travel with the data.
    task automatic do_op(input string tag, input logic [15:0] va, input logic [15:0] vb,
                         input logic vsub, input logic vsat, input logic vpk,
                         input logic [15:0] esum, input logic ecout, input logic eovf);
        drive(va, vb, vsub, vsat, vpk);
        #1 check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        sub = ~vsub; sat = ~vsat; pk = ~vpk; a = ~va; b = ~vb;
        check({tag, "_vld_t1"}, 32'(out_valid), 32'd0);
        @(negedge clk);
        check({tag, "_vld_t2"}, 32'(out_valid), 32'd1);
        check({tag, "_sum"}, 32'(sum), 32'(esum));
        check({tag, "_cout"}, 32'(cout), 32'(ecout));
        check({tag, "_ovf"}, 32'(ovf), 32'(eovf));
`ifdef ADDSUB_FLAGS_EN
        check({tag, "_zero"}, 32'(zero), 32'(esum == 16'h0000));
        check({tag, "_neg"}, 32'(neg), 32'(esum[15]));
`endif
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = 16'h0000; b = 16'h0000; sub = 1'b0; sat = 1'b0; pk = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        rst = 1'b0;

        // Full-width arithmetic and saturation
        do_op("add_sat_pos", 16'h7FFF, 16'h0001, 1'b0, 1'b1, 1'b0, 16'h7FFF, 1'b0, 1'b1);
        do_op("add_wrap",    16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        do_op("sub_sat_neg", 16'h8000, 16'h0001, 1'b1, 1'b1, 1'b0, 16'h8000, 1'b1, 1'b1);
        do_op("sub_3_5",     16'h0003, 16'h0005, 1'b1, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0);
        do_op("half_carry",  16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
        do_op("wrap_zero",   16'hFFFF, 16'h0001, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);

        // Packed lanes: no carry or borrow across 4-bit boundaries
        do_op("pk_sub_sat",  16'h7830, 16'h1150, 1'b1, 1'b1, 1'b1, 16'h68E0, 1'b1, 1'b1);
        do_op("pk_sub_wrap", 16'h7830, 16'h1150, 1'b1, 1'b0, 1'b1, 16'h67E0, 1'b1, 1'b1);
        do_op("pk_add_iso",  16'h0F0F, 16'h0101, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0);
        do_op("pk_add_sat",  16'h7777, 16'h1111, 1'b0, 1'b1, 1'b1, 16'h7777, 1'b0, 1'b1);

        // Back-pressure: four back-to-back operations, 3-cycle consumer stall
        @(negedge clk);
        drive(16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("bp_rdy_op1", 32'(in_ready), 32'd1);
        drive(16'h1000, 16'h0234, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("bp_vld0", 32'(out_valid), 32'd1);
        check("bp_sum0", 32'(sum), 32'h0003);
        out_ready = 1'b0;
        drive(16'h0F0F, 16'h00F1, 1'b0, 1'b0, 1'b0);
        #1 check("bp_full_rdy", 32'(in_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_hold_vld", 32'(out_valid), 32'd1);
            check("bp_hold_sum", 32'(sum), 32'h0003);
            check("bp_hold_rdy", 32'(in_ready), 32'(i == 2 ? 0 : 0));
            if (i == 2) out_ready = 1'b1;
        end
        #1 check("bp_release_rdy", 32'(in_ready), 32'd1);
        @(negedge clk);
        check("bp_sum1", 32'(sum), 32'h1234);
        drive(16'h0005, 16'h0007, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        check("bp_sum2", 32'(sum), 32'h1000);
        in_valid = 1'b0;
        @(negedge clk);
        check("bp_vld3", 32'(out_valid), 32'd1);
        check("bp_sum3", 32'(sum), 32'hFFFE);
        check("bp_cout3", 32'(cout), 32'd0);
        @(negedge clk);
        check("bp_drained", 32'(out_valid), 32'd0);

        // Reset with two operations in flight
        drive(16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        drive(16'h4444, 16'h0001, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        #1 check("mid_rst_rdy", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        check("post_rst_vld", 32'(out_valid), 32'd0);
        check("post_rst_sum", 32'(sum), 32'd0);
        do_op("post_rst_op", 16'h1234, 16'h0FFF, 1'b0, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0);
        @(negedge clk);
        check("post_rst_idle", 32'(out_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/addsub_pipe.md
# addsub_pipe

Parametrised, two-stage pipelined saturating adder/subtractor built from 4-bit carry-lookahead lanes. It extends the 4-bit CLA add/sub to WIDTH bits and adds a packed mode of independent 4-bit lanes for the sub-word add instruction. It adds a valid/ready handshake and overflow/carry flags. It sits in the EX stage of the pipeline and feeds the ALU result mux and the flag register.

## Interface
- WIDTH, 16, operand/result width in bits; multiple of 8, minimum 8.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept operands this cycle.
- a  in  WIDTH  operand A (two's complement).
- b  in  WIDTH  operand B (two's complement).
- sub  in  1  0: A+B, 1: A−B.
- sat  in  1  1: saturate signed overflow; 0: wrap.
- packed  in  1  0: one WIDTH-bit operation; 1: WIDTH/4 independent 4-bit lanes.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- sum  out  WIDTH  result.
- cout  out  1  raw carry-out of the top bit. In packed mode, carry-out of the top lane. For sub, 1 means no borrow.
- ovf  out  1  signed overflow before saturation. In packed mode, OR of all lanes.

## Operation
- Subtraction: B is inverted and carry-in is 1. In packed mode, every lane gets carry-in 1. There is no external carry-in.
- Full mode:
  - Stage 1 computes the low WIDTH/2 bits with chained CLA lanes.
  - Stage 1 registers the low result, the boundary carry, the upper A half, the upper (inverted) B half and the control bits.
  - Stage 2 computes the upper half from the registered carry.
- Packed mode: no carry crosses a 4-bit lane boundary. Lanes below WIDTH/2 are resolved in stage 1; the remaining lanes are resolved in stage 2.
- Overflow: set when the operand signs (after B inversion) are equal and the result sign differs. It is evaluated per lane in packed mode and at the top bit in full mode.
- Saturation, applied only when sat=1 and overflow is set:
  - Positive overflow gives 0111…1 (per lane: 4'b0111).
  - Negative overflow gives 1000…0 (per lane: 4'b1000).
- ovf and cout always reflect the raw result, regardless of sat.
- sub, sat and packed are sampled with the operands on acceptance and travel with the data. Changing them later has no effect on in-flight operations.

## Timing
- Operands are accepted when in_valid && in_ready, in cycle t.
- With no stall, out_valid rises at t+2. Throughput is one operation per cycle.
- in_ready = !s1_valid || (!s2_valid || out_ready). It is combinational and carries no path from in_valid.
- Stall: while out_valid && !out_ready, sum/cout/ovf are held stable. Stage 1 advances only into an empty or draining stage 2. Nothing is dropped or duplicated.
- Results leave in acceptance order.
- Reset values: out_valid=0, sum=0, cout=0, ovf=0, all internal valid bits 0.
- in_ready is 0 while rst=1 and 1 in the first cycle after rst deasserts.
- Reset mid-operation discards all in-flight operations. No partial results appear.
- When in_valid=0, pipeline registers may hold stale data, but out_valid stays 0.

## Configuration
- ADDSUB_FLAGS_EN defined: adds two outputs, both registered alongside sum and reset to 0.
  - zero (1): sum == 0 after saturation.
  - neg (1): sum[WIDTH-1].
- ADDSUB_FLAGS_EN undefined: these ports and their logic are absent; all other behaviour is identical.

## Structure
- Package addsub_pkg holds:
  - localparam LANE_W=4;
  - the saturation constants LANE_POS_MAX and LANE_NEG_MIN;
  - the packed struct for stage-1 payload (low result, carry, upper operands, sub/sat/packed).
- Sub-module cla_lane4 is a 4-bit CLA with cin, sum, cout and lane overflow. The top module instantiates WIDTH/4 of these.

## Test plan
- Full mode, WIDTH=16, add, sat=1, a=0x7FFF, b=0x0001: two cycles later sum=0x7FFF, ovf=1, cout=0. Repeat with sat=0: sum=0x8000, ovf=1.
- Full mode, sub, sat=1, a=0x8000, b=0x0001: sum=0x8000, ovf=1. Separately, sub, a=0x0003, b=0x0005: sum=0xFFFE, cout=0, ovf=0.
- Half-boundary carry, add, a=0x00FF, b=0x0001: sum=0x0100, cout=0. Then a=0xFFFF, b=0x0001: sum=0x0000, cout=1, ovf=0.
- Packed sub, a=0x7830, b=0x1150:
  - sat=1: sum=0x68E0, ovf=1.
  - sat=0: sum=0x67E0, ovf=1.
  - Confirms no inter-lane borrow.
- Back-pressure: 4 back-to-back operations with out_ready held low for 3 cycles from the first out_valid.
  - in_ready drops once both stages are full.
  - sum is held stable while stalled.
  - All 4 results appear in order with no loss.
- Reset with 2 operations in flight: out_valid=0 and sum=0 the cycle after rst. The first post-reset operation returns its correct result at t+2.
